audio_gain_feeder: RTL

//  Upstream feeder for i2s_master in the clk_soc domain: accepts stereo 24-bit sample pairs over a

---
 rtl/audio_pkg.sv | 27 ++
 rtl/audio_gain_sat.sv | 27 ++
 rtl/audio_gain_feeder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared widths, sample/gain types and the saturation helpers for the audio gain path.
// Products are PROD_W bits; GAIN_SHIFT turns the Q1.7 gain product back into sample scale.
package audio_pkg;
  localparam int SAMPLE_W   = 24;
  localparam int GAIN_W     = 8;
  localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;
  localparam int GAIN_SHIFT = GAIN_W - 1;
  localparam int UNITY_GAIN = 1 << GAIN_SHIFT;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [GAIN_W-1:0]   gain_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // A value fits in a sample only if every bit above the sample MSB repeats the sign.
  function automatic logic is_clip(input logic signed [PROD_W-1:0] v);
    return !((&v[PROD_W-1:SAMPLE_W-1]) || !(|v[PROD_W-1:SAMPLE_W-1]));
  endfunction

  function automatic sample_t saturate(input logic signed [PROD_W-1:0] v);
    if (is_clip(v)) begin
      return v[PROD_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
    return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/audio_gain_sat.sv
// One channel: signed sample times unsigned Q1.7 gain, arithmetic shift, saturate, clip flag.
// Purely combinational; sits between the stage A and stage B registers of the feeder.
module audio_gain_sat
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] x,
  input  logic [GAIN_W-1:0]   g,
  output logic [SAMPLE_W-1:0] y,
  output logic                clip
);

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] g_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;

  always_comb begin
    x_ext  = {{(PROD_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    g_ext  = {{(PROD_W-GAIN_W){1'b0}}, g};
    prod   = x_ext * g_ext;
    // >>> on a signed value floors, so negative results round toward -inf.
    scaled = prod >>> GAIN_SHIFT;
    y      = saturate(scaled);
    clip   = is_clip(scaled);
  end

endmodule

// File: rtl/audio_gain_feeder.sv
// Stereo gain/mute/saturate feeder into i2s_master: 2-stage pipeline, backpressured by full.
// Optional AUDIO_GAIN_SOFT_RAMP_EN: gains slew 1 LSB per accepted pair instead of stepping.
module audio_gain_feeder
  import audio_pkg::*;
#(
  parameter int CLIP_CNT_W = 16
) (
  input  logic                  clk_soc,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SAMPLE_W-1:0]   in_l,
  input  logic [SAMPLE_W-1:0]   in_r,
  input  logic [GAIN_W-1:0]     gain_l,
  input  logic [GAIN_W-1:0]     gain_r,
  input  logic                  mute,
  input  logic                  full,
  output logic                  write_frame,
  output logic [SAMPLE_W-1:0]   frame_in_l,
  output logic [SAMPLE_W-1:0]   frame_in_r,
  output logic [CLIP_CNT_W-1:0] clip_count,
  input  logic                  clip_clr
);

  logic adv_a, adv_b, accept;
  gain_t tgt_l, tgt_r, use_l, use_r;

  logic    valid_a_q, valid_a_d;
  sample_t a_l_q, a_l_d, a_r_q, a_r_d;
  gain_t   a_gl_q, a_gl_d, a_gr_q, a_gr_d;

  logic    valid_b_q, valid_b_d;
  sample_t out_l_q, out_l_d, out_r_q, out_r_d;
  logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;

  logic [SAMPLE_W-1:0] y_l, y_r;
  logic clip_l, clip_r;

  always_comb begin
    tgt_l       = mute ? '0 : gain_l;
    tgt_r       = mute ? '0 : gain_r;
    adv_b       = ~valid_b_q | ~full;
    adv_a       = ~valid_a_q | adv_b;
    in_ready    = adv_a & reset_n;
    accept      = in_valid & in_ready;
    write_frame = valid_b_q & ~full & reset_n;
  end

`ifdef AUDIO_GAIN_SOFT_RAMP_EN
  gain_t cur_l_q, cur_l_d, cur_r_q, cur_r_d;

  function automatic gain_t step_toward(input gain_t cur, input gain_t tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  // The accepted pair uses the gain held before this step, so a ramp starts from the old gain.
  always_comb begin
    cur_l_d = cur_l_q;
    cur_r_d = cur_r_q;
    if (accept) begin
      cur_l_d = step_toward(cur_l_q, tgt_l);
      cur_r_d = step_toward(cur_r_q, tgt_r);
    end
    use_l = cur_l_q;
    use_r = cur_r_q;
  end

  always_ff @(posedge clk_soc) begin
    if (!reset_n) begin
      cur_l_q <= tgt_l;
      cur_r_q <= tgt_r;
    end else begin
      cur_l_q <= cur_l_d;
      cur_r_q <= cur_r_d;
    end
  end
`else
  always_comb begin
    use_l = tgt_l;
    use_r = tgt_r;
  end
`endif

  audio_gain_sat u_sat_l (.x(a_l_q), .g(a_gl_q), .y(y_l), .clip(clip_l));
  audio_gain_sat u_sat_r (.x(a_r_q), .g(a_gr_q), .y(y_r), .clip(clip_r));

  always_comb begin
    valid_a_d  = valid_a_q;
    a_l_d      = a_l_q;
    a_r_d      = a_r_q;
    a_gl_d     = a_gl_q;
    a_gr_d     = a_gr_q;
    valid_b_d  = valid_b_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    clip_cnt_d = clip_cnt_q;

    if (adv_a) valid_a_d = accept;
    if (accept) begin
      a_l_d  = in_l;
      a_r_d  = in_r;
      a_gl_d = use_l;
      a_gr_d = use_r;
    end

    if (adv_b) valid_b_d = valid_a_q;
    if (adv_b && valid_a_q) begin
      out_l_d = y_l;
      out_r_d = y_r;
    end

    if (clip_clr) begin
      clip_cnt_d = '0;
    end else if (adv_b && valid_a_q && (clip_l || clip_r) && !(&clip_cnt_q)) begin
      clip_cnt_d = clip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_soc) begin
    if (!reset_n) begin
      valid_a_q  <= 1'b0;
      a_l_q      <= '0;
      a_r_q      <= '0;
      a_gl_q     <= '0;
      a_gr_q     <= '0;
      valid_b_q  <= 1'b0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      clip_cnt_q <= '0;
    end else begin
      valid_a_q  <= valid_a_d;
      a_l_q      <= a_l_d;
      a_r_q      <= a_r_d;
      a_gl_q     <= a_gl_d;
      a_gr_q     <= a_gr_d;
      valid_b_q  <= valid_b_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign frame_in_l = out_l_q;
  assign frame_in_r = out_r_q;
  assign clip_count = clip_cnt_q;

endmodule
